// File: rtl/acc_lut_search.sv
// acc_lut_search: reverse lookup of a byte in a fixed 8-entry table, one entry per cycle.
module acc_lut_search #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] value_in,
    input  logic       ack,
    output logic       ready,
    output logic       done,
    output logic       hit,
    output logic [4:0] key
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    localparam logic [63:0] TABLE = {8'h80, 8'd66, 8'd65, 8'd64, 8'd1, 8'd0, 8'd63, 8'hFF};
    state_t     state;
    logic [2:0] idx;
    logic [7:0] val;
    logic       found;
    logic [2:0] found_idx;
    logic       match;
    assign match = val == TABLE[idx*8 +: 8];
    assign ready = state == IDLE;
    assign done  = state == DONE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            val       <= 8'd0;
            found     <= 1'b0;
            found_idx <= 3'd0;
            key       <= 5'h1F;
            hit       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state <= SEARCH;
                    val   <= value_in;
                    idx   <= 3'd0;
                    found <= 1'b0;
                end
                SEARCH: begin
                    if (EARLY_EXIT && match) begin
                        state <= DONE;
                        key   <= {2'b00, idx};
                        hit   <= 1'b1;
                    end else if (idx == 3'd7) begin
                        // the earliest recorded match wins over a match on the last entry
                        state <= DONE;
                        hit   <= found || match;
                        key   <= found ? {2'b00, found_idx} : match ? {2'b00, idx} : 5'h1F;
                    end else begin
                        idx <= idx + 3'd1;
                        if (match && !found) begin
                            found     <= 1'b1;
                            found_idx <= idx;
                        end
                    end
                end
                DONE: if (ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_lut_search.sv
// tb_acc_lut_search: drives an early-exit and a full-scan instance against a table-scan model.
module tb_acc_lut_search;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] ack = 2'b00;
    logic [1:0] ready, done, hit;
    logic [7:0] vin [2];
    logic [4:0] key [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // index 1: EARLY_EXIT=1, index 0: EARLY_EXIT=0
    acc_lut_search #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .value_in(vin[1]), .ack(ack[1]),
        .ready(ready[1]), .done(done[1]), .hit(hit[1]), .key(key[1])
    );
    acc_lut_search #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .value_in(vin[0]), .ack(ack[0]),
        .ready(ready[0]), .done(done[0]), .hit(hit[0]), .key(key[0])
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [7:0] v, input int e, output int h, output int k, output int lat);
        logic [7:0] t [8] = '{8'hFF, 8'd63, 8'd0, 8'd1, 8'd64, 8'd65, 8'd66, 8'h80};
        h = 0;
        k = 31;
        lat = 8;
        for (int i = 0; i < 8; i++)
            if (h == 0 && t[i] == v) begin
                h = 1;
                k = i;
                if (e == 1) lat = i + 1;
            end
    endfunction

    task automatic run(input int e, input logic [7:0] v);
        int h, k, lat, n;
        model(v, e, h, k, lat);
        chk("ready_idle", int'(ready[e]), 1);
        vin[e] = v;
        req[e] = 1'b1;
        @(posedge clk); #1;
        chk("ready_in_search", int'(ready[e]), 0);
        req[e] = 1'($urandom);
        ack[e] = 1'($urandom);
        vin[e] = 8'($urandom);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done[e]) break;
            req[e] = 1'($urandom);
            ack[e] = 1'($urandom);
            vin[e] = 8'($urandom);
        end
        req[e] = 1'b0;
        ack[e] = 1'b0;
        chk($sformatf("latency v=%0h ee=%0d", v, e), n, lat);
        chk($sformatf("key v=%0h ee=%0d", v, e), int'(key[e]), k);
        chk($sformatf("hit v=%0h ee=%0d", v, e), int'(hit[e]), h);
        repeat (2) begin
            req[e] = 1'($urandom);
            @(posedge clk); #1;
            chk("done_held", int'(done[e]), 1);
            chk("key_held", int'(key[e]), k);
            chk("hit_held", int'(hit[e]), h);
        end
        req[e] = 1'b1;
        ack[e] = 1'b1;
        @(posedge clk); #1;
        req[e] = 1'b0;
        ack[e] = 1'b0;
        chk("done_after_ack", int'(done[e]), 0);
        chk("ready_after_ack", int'(ready[e]), 1);
        chk("key_idle_hold", int'(key[e]), k);
        chk("hit_idle_hold", int'(hit[e]), h);
        @(posedge clk); #1;
        chk("req_not_queued", int'(ready[e]), 1);
    endtask

    initial begin
        logic [7:0] tv [8] = '{8'hFF, 8'd63, 8'd0, 8'd1, 8'd64, 8'd65, 8'd66, 8'h80};
        vin[0] = 8'd0;
        vin[1] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 0; e < 2; e++) begin
            chk("rst_ready", int'(ready[e]), 1);
            chk("rst_done", int'(done[e]), 0);
            chk("rst_key", int'(key[e]), 31);
            chk("rst_hit", int'(hit[e]), 0);
        end
        ack = 2'b11;
        @(posedge clk); #1;
        ack = 2'b00;
        chk("ack_in_idle", int'(ready), 3);
        run(1, 8'd0);
        run(1, 8'hFF);
        run(1, 8'h80);
        run(1, 8'd5);
        run(0, 8'd63);
        run(0, 8'd0);
        run(0, 8'd5);
        for (int i = 0; i < 24; i++)
            run(i % 2, ($urandom_range(0, 1) == 1) ? tv[$urandom_range(0, 7)] : 8'($urandom));
        vin[1] = 8'h80;
        req[1] = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_done", int'(done[1]), 0);
        chk("abort_ready", int'(ready[1]), 1);
        chk("abort_key", int'(key[1]), 31);
        chk("abort_hit", int'(hit[1]), 0);
        repeat (10) begin
            @(posedge clk); #1;
            chk("abort_no_done", int'(done[1]), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
